// File: rtl/operand_hazard_scoreboard_pkg.sv
// Shared core definitions for operand forwarding and hazard tracking.
// The forward-select encoding is also consumed by the EX operand muxes.
package operand_hazard_scoreboard_pkg;

   localparam int FwdSelWidth = 3;

   typedef enum logic [FwdSelWidth-1:0] {
      FWD_RF      = 3'b000,
      FWD_MEM_ALU = 3'b001,
      FWD_MEM_LD  = 3'b010,
      FWD_WB      = 3'b100
   } fwd_sel_e;

endpackage

// File: rtl/operand_hazard_scoreboard_if.sv
// ID/EX/MEM/WB control and long-op completion bundle seen by the hazard scoreboard.
// master = pipeline control driving it, slave = the scoreboard.
interface operand_hazard_scoreboard_if #(
   parameter int RegAddrWidth = 5,
   parameter int NumReadPorts = 2,
   parameter int MaxPending   = 4
);
   localparam int CntWidth = $clog2(MaxPending + 1);

   logic                                 id_valid_i;
   logic [NumReadPorts*RegAddrWidth-1:0] id_rs_i;
   logic [NumReadPorts-1:0]              id_rs_used_i;
   logic [RegAddrWidth-1:0]              id_rd_i;
   logic                                 id_rd_wr_i;
   logic                                 id_long_op_i;
   logic                                 flush_i;
   logic [NumReadPorts*RegAddrWidth-1:0] ex_rs_i;
   logic [RegAddrWidth-1:0]              ex_rd_i;
   logic                                 ex_rd_wr_i;
   logic                                 ex_load_i;
   logic [RegAddrWidth-1:0]              mem_rd_i;
   logic                                 mem_rd_wr_i;
   logic                                 mem_load_i;
   logic [RegAddrWidth-1:0]              wb_rd_i;
   logic                                 wb_rd_wr_i;
   logic                                 lop_done_i;
   logic [RegAddrWidth-1:0]              lop_done_rd_i;
   logic [NumReadPorts*3-1:0]            fwd_sel_o;
   logic                                 stall_o;
   logic                                 issue_o;
   logic [CntWidth-1:0]                  pend_cnt_o;
   logic                                 busy_o;

   modport master (
      output id_valid_i, id_rs_i, id_rs_used_i, id_rd_i, id_rd_wr_i, id_long_op_i, flush_i,
             ex_rs_i, ex_rd_i, ex_rd_wr_i, ex_load_i, mem_rd_i, mem_rd_wr_i, mem_load_i,
             wb_rd_i, wb_rd_wr_i, lop_done_i, lop_done_rd_i,
      input  fwd_sel_o, stall_o, issue_o, pend_cnt_o, busy_o
   );

   modport slave (
      input  id_valid_i, id_rs_i, id_rs_used_i, id_rd_i, id_rd_wr_i, id_long_op_i, flush_i,
             ex_rs_i, ex_rd_i, ex_rd_wr_i, ex_load_i, mem_rd_i, mem_rd_wr_i, mem_load_i,
             wb_rd_i, wb_rd_wr_i, lop_done_i, lop_done_rd_i,
      output fwd_sel_o, stall_o, issue_o, pend_cnt_o, busy_o
   );

endinterface

// File: rtl/operand_hazard_scoreboard_fwd_port_sel.sv
// Bypass source selection for one EX read port; MEM outranks WB, register 0 never forwards.
module fwd_port_sel
   import operand_hazard_scoreboard_pkg::*;
#(
   parameter int RegAddrWidth = 5
) (
   input  logic [RegAddrWidth-1:0] rs,
   input  logic [RegAddrWidth-1:0] mem_rd,
   input  logic                    mem_wr,
   input  logic                    mem_load,
   input  logic [RegAddrWidth-1:0] wb_rd,
   input  logic                    wb_wr,
   output fwd_sel_e                sel
);

   always_comb begin
      sel = FWD_RF;
      if (rs != '0 && mem_wr && mem_rd == rs) begin
         sel = mem_load ? FWD_MEM_LD : FWD_MEM_ALU;
      end else if (rs != '0 && wb_wr && wb_rd == rs) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/operand_hazard_scoreboard.sv
// EX operand forwarding, load-use interlock and a per-register scoreboard for
// long-latency results that retire out of band.
module operand_hazard_scoreboard
   import operand_hazard_scoreboard_pkg::*;
#(
   parameter int RegAddrWidth = 5,
   parameter int NumReadPorts = 2,
   parameter int MaxPending   = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   operand_hazard_scoreboard_if.slave  bus
);

   localparam int NumRegs  = 2 ** RegAddrWidth;
   localparam int CntWidth = $clog2(MaxPending + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxPending);

   logic [NumRegs-1:0]        pending;
   logic [CntWidth-1:0]       cnt;
   fwd_sel_e                  sel [NumReadPorts];
   logic [NumReadPorts*3-1:0] fwd_sel_flat;
   logic [NumReadPorts-1:0]   load_use_hit;
   logic [NumReadPorts-1:0]   raw_hit;
   logic                      waw_hit;
   logic                      cap_hit;
   logic                      stall;
   logic                      issue;
   logic                      cnt_inc;
   logic                      set_pend;

   for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
      logic [RegAddrWidth-1:0] ex_rs;
      logic [RegAddrWidth-1:0] id_rs;

      assign ex_rs = bus.ex_rs_i[p*RegAddrWidth +: RegAddrWidth];
      assign id_rs = bus.id_rs_i[p*RegAddrWidth +: RegAddrWidth];

      fwd_port_sel #(.RegAddrWidth(RegAddrWidth)) u_sel (
         .rs       (ex_rs),
         .mem_rd   (bus.mem_rd_i),
         .mem_wr   (bus.mem_rd_wr_i),
         .mem_load (bus.mem_load_i),
         .wb_rd    (bus.wb_rd_i),
         .wb_wr    (bus.wb_rd_wr_i),
         .sel      (sel[p])
      );

      assign load_use_hit[p] = bus.id_rs_used_i[p] && id_rs != '0 && bus.ex_rd_wr_i &&
                               bus.ex_load_i && bus.ex_rd_i == id_rs;
      // pending[0] is never set, so register 0 cannot raise a RAW hit.
      assign raw_hit[p] = bus.id_rs_used_i[p] && pending[id_rs];
   end

   always_comb begin
      fwd_sel_flat = '0;
      for (int p = 0; p < NumReadPorts; p++) begin
         fwd_sel_flat[p*3 +: 3] = sel[p];
      end
   end

   assign waw_hit  = bus.id_rd_wr_i && bus.id_rd_i != '0 && pending[bus.id_rd_i];
   assign cap_hit  = bus.id_long_op_i && cnt == CntMax;
   assign stall    = bus.id_valid_i && (|load_use_hit || |raw_hit || waw_hit || cap_hit);
   assign issue    = bus.id_valid_i && !stall && !bus.flush_i;
   assign cnt_inc  = issue && bus.id_long_op_i;
   assign set_pend = cnt_inc && bus.id_rd_wr_i && bus.id_rd_i != '0;

   // Set after clear so an issue and completion on the same register leaves it pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         cnt     <= '0;
      end else begin
         if (bus.lop_done_i) pending[bus.lop_done_rd_i] <= 1'b0;
         if (set_pend)       pending[bus.id_rd_i]       <= 1'b1;
         if (cnt_inc && !bus.lop_done_i) begin
            cnt <= cnt + CntWidth'(1);
         end else if (!cnt_inc && bus.lop_done_i && cnt != '0) begin
            cnt <= cnt - CntWidth'(1);
         end
      end
   end

   assign bus.fwd_sel_o  = fwd_sel_flat;
   assign bus.stall_o    = stall;
   assign bus.issue_o    = issue;
   assign bus.pend_cnt_o = cnt;
   assign bus.busy_o     = cnt != '0;

`ifndef SYNTHESIS
   lop_done_legal: assert property (@(posedge clk) disable iff (!rst_n)
      bus.lop_done_i |-> cnt != '0);
`endif

endmodule
